core_if: RTL and testbench



---
 rtl/core_if.sv | 187 ++++++++++++++++++
 tb/tb_core_if.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_if.sv
// core_if -- instruction fetch stage of the i2d core.
//
// Keeps the fetch PC, issues single-outstanding word reads on the instruction
// memory port, buffers returned words in a QDEPTH-entry prefetch queue and
// presents the queue head to decode. Handles redirects, exceptions, decode
// stalls and fetch bus errors. Inserts NOP bubbles when the queue is empty.
//
// Parameters:
//   RESET_PC    fetch address after reset
//   QDEPTH      prefetch queue entries (power of two, >= 2)
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   imem_req/imem_addr        registered read request and word address
//   imem_ack/rdata/err        completion, data and bus error from memory
//   id_halt                   decode stalled, head not consumed
//   redirect/redirect_pc      taken branch / call / ret / rfe target
//   exc/exc_vector            exception entry target (wins over redirect)
//   if_pc/if_instr            head PC and instruction (bubble when empty/err)
//   if_valid/if_err           head is a real fetch / head came from a fault
module core_if #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        imem_err,
  input  logic        id_halt,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        exc,
  input  logic [31:0] exc_vector,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_valid,
  output logic        if_err
);

  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  localparam logic [5:0]  OPCODE_NOP = 6'h00;
  localparam logic [31:0] BUBBLE     = {OPCODE_NOP, 26'(2)};
  localparam logic [31:0] RESET_FPC  = RESET_PC & 32'hFFFF_FFFC;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DROP, S_ERR} state_t;

  state_t        state;
  logic [31:0]   fpc;

  logic [31:0]   q_pc    [QDEPTH];
  logic [31:0]   q_instr [QDEPTH];
  logic          q_err   [QDEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic          redir;
  logic [31:0]   target;
  logic [31:0]   fpc_inc;
  logic          head_valid;
  logic          pop;
  logic          push;
  logic [CW:0]   occ;
  logic          credit;

  always_comb begin
    redir      = redirect | exc;
    target     = (exc ? exc_vector : redirect_pc) & 32'hFFFF_FFFC;
    fpc_inc    = fpc + 32'd4;
    head_valid = (count != '0);

    if_valid   = head_valid;
    if_err     = head_valid & q_err[rd_ptr];
    if_pc      = head_valid ? q_pc[rd_ptr] : fpc;
    if_instr   = (head_valid && !q_err[rd_ptr]) ? q_instr[rd_ptr] : BUBBLE;

    pop        = head_valid & ~id_halt & ~redir;
    push       = (state == S_FETCH) & imem_ack & ~redir;

    // In FETCH the outstanding word is counted as already occupying a slot,
    // so an ack plus immediate reissue never oversubscribes the queue.
    occ        = (CW + 1)'(count) + (CW + 1)'(state == S_FETCH) - (CW + 1)'(pop);
    credit     = occ < (CW + 1)'(QDEPTH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      imem_req  <= 1'b0;
      imem_addr <= RESET_FPC;
      fpc       <= RESET_FPC;
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
    end else begin
      // Prefetch queue
      if (redir) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          q_pc[wr_ptr]    <= imem_addr;
          q_instr[wr_ptr] <= imem_rdata;
          q_err[wr_ptr]   <= imem_err;
          wr_ptr          <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        count <= count + CW'(push) - CW'(pop);
      end

      // Request FSM
      unique case (state)
        S_IDLE: begin
          if (redir) begin
            fpc       <= target;
            imem_addr <= target;
            imem_req  <= 1'b1;
            state     <= S_FETCH;
          end else if (credit) begin
            imem_addr <= fpc;
            imem_req  <= 1'b1;
            state     <= S_FETCH;
          end
        end

        S_FETCH: begin
          if (imem_ack) begin
            if (redir) begin
              // Returned word belongs to the old stream: drop it and go
              // straight to the target (queue is flushed, so credit holds).
              fpc       <= target;
              imem_addr <= target;
              imem_req  <= 1'b1;
            end else begin
              fpc <= fpc_inc;
              if (imem_err) begin
                imem_req <= 1'b0;
                state    <= S_ERR;
              end else if (credit) begin
                imem_addr <= fpc_inc;
                imem_req  <= 1'b1;
              end else begin
                imem_req <= 1'b0;
                state    <= S_IDLE;
              end
            end
          end else if (redir) begin
            fpc   <= target;
            state <= S_DROP;
          end
        end

        S_DROP: begin
          if (redir) begin
            fpc <= target;
          end
          if (imem_ack) begin
            imem_addr <= redir ? target : fpc;
            imem_req  <= 1'b1;
            state     <= S_FETCH;
          end
        end

        S_ERR: begin
          imem_req <= 1'b0;
          if (redir) begin
            fpc   <= target;
            state <= S_IDLE;
          end
        end

        default: begin
          imem_req <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_if.sv
// Testbench for core_if: memory responder with configurable wait states and
// an expected-instruction-stream model checked on every consumed instruction.
module tb_core_if;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned QDEPTH   = 2;
  localparam logic [31:0] BUBBLE   = {6'h00, 26'd2};

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_err;
  logic        id_halt;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        exc;
  logic [31:0] exc_vector;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;
  logic        if_err;

  int n_cmp  = 0;
  int n_fail = 0;

  // memory model controls
  int unsigned lat_fixed = 0;
  bit          lat_rand  = 1'b0;
  bit          data_inv  = 1'b0;
  bit          err_en    = 1'b0;
  logic [31:0] err_addr  = 32'h0;
  int unsigned lat_cur   = 0;
  int unsigned wait_cnt  = 0;

  always #5 clk = ~clk;

  core_if #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .imem_err(imem_err),
    .id_halt(id_halt), .redirect(redirect), .redirect_pc(redirect_pc),
    .exc(exc), .exc_vector(exc_vector),
    .if_pc(if_pc), .if_instr(if_instr), .if_valid(if_valid), .if_err(if_err)
  );

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return data_inv ? ~a : a;
  endfunction

  always_comb begin
    imem_ack   = imem_req && (wait_cnt >= lat_cur);
    imem_rdata = data_of(imem_addr);
    imem_err   = imem_ack && err_en && (imem_addr == err_addr);
  end

  always @(posedge clk) begin
    if (rst || !imem_req) begin
      wait_cnt <= 0;
      lat_cur  <= lat_rand ? $urandom_range(0, 3) : lat_fixed;
    end else if (imem_ack) begin
      wait_cnt <= 0;
      lat_cur  <= lat_rand ? $urandom_range(0, 3) : lat_fixed;
    end else begin
      wait_cnt <= wait_cnt + 1;
    end
  end

  task automatic do_reset();
    rst = 1'b1; id_halt = 1'b0; redirect = 1'b0; exc = 1'b0;
    redirect_pc = '0; exc_vector = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; id_halt = 1'b0; redirect = 1'b0; exc = 1'b0;
    redirect_pc = '0; exc_vector = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
    n_cmp++; if (imem_addr !== RESET_PC) begin n_fail++; $display("FAIL reset_addr: got %h want %h", imem_addr, RESET_PC); end
    n_cmp++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", if_valid); end
    n_cmp++; if (if_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", if_err); end
    n_cmp++; if (if_instr !== BUBBLE) begin n_fail++; $display("FAIL reset_instr: got %h want %h", if_instr, BUBBLE); end
    n_cmp++; if (if_pc !== RESET_PC) begin n_fail++; $display("FAIL reset_pc: got %h want %h", if_pc, RESET_PC); end
  endtask

  // Zero-wait memory returning addr as data: 0,4,8,... every cycle.
  task automatic test_stream();
    lat_fixed = 0; lat_rand = 1'b0; data_inv = 1'b0; err_en = 1'b0;
    do_reset();
    @(negedge clk);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin n_fail++; $display("FAIL stream_first_req: got req=%b addr=%h want 1/%h", imem_req, imem_addr, RESET_PC); end
    n_cmp++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL stream_early_valid: got %b want 0", if_valid); end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      n_cmp++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b want 1", k, if_valid); end
      n_cmp++; if (if_pc !== RESET_PC + 32'(4 * k) || if_instr !== RESET_PC + 32'(4 * k))
        begin n_fail++; $display("FAIL stream_data[%0d]: got pc=%h instr=%h want %h", k, if_pc, if_instr, RESET_PC + 32'(4 * k)); end
    end
  endtask

  // Decode halt for 5 cycles mid-stream: head holds, requests stop, no loss.
  task automatic test_halt();
    logic [31:0] exp;
    lat_fixed = 0; lat_rand = 1'b0; data_inv = 1'b0; err_en = 1'b0;
    do_reset();
    exp = RESET_PC;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      id_halt = (c >= 8 && c < 13);
      if (id_halt) begin
        n_cmp++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL halt_valid[%0d]: got %b want 1", c, if_valid); end
      end
      if (c == 12) begin
        n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL halt_req_drop: got %b want 0", imem_req); end
      end
      if (if_valid) begin
        n_cmp++; if (if_pc !== exp || if_instr !== exp) begin n_fail++; $display("FAIL halt_order[%0d]: got pc=%h instr=%h want %h", c, if_pc, if_instr, exp); end
        if (!id_halt) exp = exp + 32'd4;
      end
    end
    id_halt = 1'b0;
    n_cmp++; if (exp < 32'd100) begin n_fail++; $display("FAIL halt_progress: got next pc %h want >= 00000064", exp); end
  endtask

  // 3-cycle memory; redirect in first wait cycle drops the in-flight word.
  task automatic test_drop();
    bit seen_ack, req_chk, done;
    lat_fixed = 3; lat_rand = 1'b0; data_inv = 1'b0; err_en = 1'b0;
    do_reset();
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    redirect = 1'b0;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin n_fail++; $display("FAIL drop_hold: got req=%b addr=%h want 1/%h", imem_req, imem_addr, RESET_PC); end
    seen_ack = 1'b0; req_chk = 1'b0; done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      if (i > 0) @(negedge clk);
      if (!seen_ack) begin
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin n_fail++; $display("FAIL drop_addr_held: got req=%b addr=%h want 1/%h", imem_req, imem_addr, RESET_PC); end
        if (imem_ack) seen_ack = 1'b1;
      end else if (!req_chk) begin
        req_chk = 1'b1;
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_fail++; $display("FAIL drop_next_req: got req=%b addr=%h want 1/00000100", imem_req, imem_addr); end
      end
      if (if_valid) begin
        done = 1'b1;
        n_cmp++; if (if_pc !== 32'h100 || if_instr !== 32'h100) begin n_fail++; $display("FAIL drop_first_valid: got pc=%h instr=%h want 00000100", if_pc, if_instr); end
      end
    end
    n_cmp++; if (!done) begin n_fail++; $display("FAIL drop_timeout: got no valid output want pc 00000100"); end
  endtask

  // exc and redirect together: exc_vector wins.
  task automatic test_exc_priority();
    bit done;
    lat_fixed = 0; lat_rand = 1'b0; data_inv = 1'b0; err_en = 1'b0;
    do_reset();
    repeat (4) @(negedge clk);
    exc = 1'b1; exc_vector = 32'h8; redirect = 1'b1; redirect_pc = 32'h40;
    @(negedge clk);
    exc = 1'b0; redirect = 1'b0;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin n_fail++; $display("FAIL exc_req: got req=%b addr=%h want 1/00000008", imem_req, imem_addr); end
    n_cmp++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL exc_flush: got valid=%b want 0", if_valid); end
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clk);
      if (if_valid) begin
        done = 1'b1;
        n_cmp++; if (if_pc !== 32'h8 || if_instr !== 32'h8) begin n_fail++; $display("FAIL exc_first: got pc=%h instr=%h want 00000008", if_pc, if_instr); end
      end
    end
    n_cmp++; if (!done) begin n_fail++; $display("FAIL exc_timeout: got no valid want pc 00000008"); end
  endtask

  // Bus error at 0xC: error entry, fetch stops until redirect to 0x20.
  task automatic test_err();
    logic [31:0] exp;
    bit seen, got_req, done;
    lat_fixed = 0; lat_rand = 1'b0; data_inv = 1'b0; err_en = 1'b1; err_addr = 32'hC;
    do_reset();
    exp = RESET_PC; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (if_valid) begin
        n_cmp++; if (if_pc !== exp) begin n_fail++; $display("FAIL err_seq_pc: got %h want %h", if_pc, exp); end
        if (exp == 32'hC) begin
          seen = 1'b1;
          n_cmp++; if (if_err !== 1'b1 || if_instr !== BUBBLE) begin n_fail++; $display("FAIL err_entry: got err=%b instr=%h want 1/%h", if_err, if_instr, BUBBLE); end
        end else begin
          n_cmp++; if (if_err !== 1'b0 || if_instr !== exp) begin n_fail++; $display("FAIL err_pre: got err=%b instr=%h want 0/%h", if_err, if_instr, exp); end
        end
        exp = exp + 32'd4;
      end
    end
    n_cmp++; if (!seen) begin n_fail++; $display("FAIL err_timeout: got no error entry want pc 0000000c"); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin n_fail++; $display("FAIL err_quiet[%0d]: got req=%b valid=%b want 0/0", i, imem_req, if_valid); end
    end
    err_en = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h20;
    @(negedge clk);
    redirect = 1'b0;
    got_req = 1'b0; done = 1'b0;
    for (int i = 0; i < 12 && !done; i++) begin
      if (i > 0) @(negedge clk);
      if (imem_req && !got_req) begin
        got_req = 1'b1;
        n_cmp++; if (imem_addr !== 32'h20) begin n_fail++; $display("FAIL err_resume_addr: got %h want 00000020", imem_addr); end
      end
      if (if_valid) begin
        done = 1'b1;
        n_cmp++; if (if_pc !== 32'h20 || if_instr !== 32'h20 || if_err !== 1'b0) begin n_fail++; $display("FAIL err_resume: got pc=%h instr=%h err=%b want 00000020/00000020/0", if_pc, if_instr, if_err); end
      end
    end
    n_cmp++; if (!done) begin n_fail++; $display("FAIL err_resume_timeout: got no valid want pc 00000020"); end
  endtask

  // Address wrap at the top of the 32-bit space.
  task automatic test_wrap();
    logic [31:0] exp;
    int n;
    lat_fixed = 0; lat_rand = 1'b0; data_inv = 1'b0; err_en = 1'b0;
    do_reset();
    repeat (3) @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    @(negedge clk);
    redirect = 1'b0;
    exp = 32'hFFFF_FFF8; n = 0;
    for (int i = 0; i < 20 && n < 3; i++) begin
      if (i > 0) @(negedge clk);
      if (imem_req && imem_addr[1:0] != 2'b00) begin
        n_cmp++; n_fail++; $display("FAIL wrap_align: got addr=%h want low bits 00", imem_addr);
      end
      if (if_valid) begin
        n_cmp++; if (if_pc !== exp || if_instr !== exp) begin n_fail++; $display("FAIL wrap_seq[%0d]: got pc=%h instr=%h want %h", n, if_pc, if_instr, exp); end
        exp = exp + 32'd4; n++;
      end
    end
    n_cmp++; if (n != 3) begin n_fail++; $display("FAIL wrap_count: got %0d want 3", n); end
  endtask

  // Random latency, halts, redirects and exceptions against the stream model.
  task automatic test_random();
    logic [31:0] exp, tgt, rpc, vec, prev_addr;
    bit prev_wait, redir_now, halt_now;
    int consumed;
    int unsigned r;
    lat_rand = 1'b1; data_inv = 1'b1; err_en = 1'b0;
    do_reset();
    exp = RESET_PC; consumed = 0; prev_wait = 1'b0; prev_addr = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (prev_wait) begin
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin n_fail++; $display("FAIL rnd_hold[%0d]: got req=%b addr=%h want 1/%h", c, imem_req, imem_addr, prev_addr); end
      end
      halt_now = ($urandom % 4) == 0;
      r = $urandom % 32;
      rpc = $urandom; vec = $urandom;
      redirect = (r == 0) || (r == 2);
      exc      = (r == 1) || (r == 2);
      redirect_pc = rpc; exc_vector = vec;
      id_halt = halt_now;
      redir_now = redirect || exc;
      tgt = (exc ? vec : rpc) & 32'hFFFF_FFFC;
      if (if_valid) begin
        n_cmp++; if (if_err !== 1'b0 || if_instr !== data_of(if_pc)) begin n_fail++; $display("FAIL rnd_data[%0d]: got pc=%h instr=%h err=%b want instr %h", c, if_pc, if_instr, if_err, data_of(if_pc)); end
        if (!halt_now && !redir_now) begin
          n_cmp++; if (if_pc !== exp) begin n_fail++; $display("FAIL rnd_order[%0d]: got pc=%h want %h", c, if_pc, exp); end
          exp = exp + 32'd4; consumed++;
        end
      end
      if (redir_now) exp = tgt;
      prev_wait = imem_req && !imem_ack;
      prev_addr = imem_addr;
    end
    @(negedge clk);
    redirect = 1'b0; exc = 1'b0; id_halt = 1'b0; lat_rand = 1'b0; data_inv = 1'b0;
    n_cmp++; if (consumed < 20) begin n_fail++; $display("FAIL rnd_progress: got %0d consumed want >= 20", consumed); end
  endtask

  initial begin
    rst = 1'b1; id_halt = 1'b0; redirect = 1'b0; exc = 1'b0;
    redirect_pc = '0; exc_vector = '0;
    test_reset();
    test_stream();
    test_halt();
    test_drop();
    test_exc_priority();
    test_err();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no completion want finish before 1ms");
    $fatal(1, "timeout");
  end

endmodule
